// File: rtl/bus_master_ctrl_pkg.sv
// Shared definitions for the bus master controller: FSM state encoding,
// default bus widths, slave-select decode bit and the slave OKAY response.
package bus_master_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 32;

  // The address MSB selects the slave: 0 -> slave 1, 1 -> slave 2.
  function automatic int sel_bit(input int addr_w);
    return addr_w - 1;
  endfunction

  localparam int DEF_SEL_BIT = DEF_ADDR_W - 1;

  // Slave response value meaning "transfer OKAY".
  localparam logic SLRSP_OKAY = 1'b1;

endpackage

// File: rtl/bus_wait_timer.sv
// Wait-for-ready timer for bus_master_ctrl. Only compiled when
// BUS_MASTER_TIMEOUT_EN is defined, so the default build carries no counter.
`ifdef BUS_MASTER_TIMEOUT_EN
module bus_wait_timer #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic count_en,
  output logic expired
);

  localparam int CW = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);

  logic [CW-1:0] cnt;

  // Count BUSY cycles without ready; cleared when a new transfer starts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= '0;
    end else if (count_en) begin
      cnt <= cnt + 1'b1;
    end
  end

  // The edge that would make the count reach LIMIT ends the wait; a ready on
  // that same edge suppresses count_en, so ready wins.
  assign expired = count_en && (cnt == CW'(LIMIT - 1));

endmodule
`endif

// File: rtl/bus_master_ctrl.sv
// Single-outstanding bus master: accepts a command in IDLE, drives the
// addressed slave while BUSY, and reports completion with a one-cycle done
// pulse plus err/timeout status.
// Optional feature macro: BUS_MASTER_TIMEOUT_EN (wait-for-ready timeout).
module bus_master_ctrl
  import bus_master_ctrl_pkg::*;
#(
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              req_write,
  output logic [ADDR_W-1:0] HADDR,
  output logic [DATA_W-1:0] HWDATA,
  output logic              HWRITE,
  output logic              hsel_1,
  output logic              hsel_2,
  input  logic              sl_rdy_1,
  input  logic              sl_rdy_2,
  input  logic              slrsp_1,
  input  logic              slrsp_2,
  output logic              done,
  output logic              err,
  output logic              timeout
);

  localparam int SB = sel_bit(ADDR_W);

  state_t state;
  state_t state_next;

  logic accept;
  logic busy;
  logic sel_2;
  logic rdy_sel;
  logic rsp_sel;
  logic expired;

  assign accept  = (state == ST_IDLE) && req_valid;
  assign busy    = (state == ST_BUSY);
  assign sel_2   = HADDR[SB];
  // Only the selected slave's handshake is looked at.
  assign rdy_sel = sel_2 ? sl_rdy_2 : sl_rdy_1;
  assign rsp_sel = sel_2 ? slrsp_2 : slrsp_1;

`ifdef BUS_MASTER_TIMEOUT_EN
  bus_wait_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .start    (accept),
    .count_en (busy && !rdy_sel),
    .expired  (expired)
  );
`else
  logic unused_cfg;
  assign unused_cfg = (TIMEOUT_CYCLES > 0);
  assign expired    = 1'b0;
`endif

  // State register; reset abandons any transfer in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and state-decoded outputs; hsel follows the state
  // combinationally so an asynchronous reset drops it at once.
  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    hsel_1     = 1'b0;
    hsel_2     = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = ST_BUSY;
      end
      ST_BUSY: begin
        hsel_1 = !sel_2;
        hsel_2 = sel_2;
        if (rdy_sel || expired) state_next = ST_DONE;
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Command registers load only on accept and hold afterwards.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      HADDR  <= '0;
      HWDATA <= '0;
      HWRITE <= 1'b0;
    end else if (accept) begin
      HADDR  <= req_addr;
      HWDATA <= req_wdata;
      HWRITE <= req_write;
    end
  end

  // Completion pulse trails the DONE state by one edge; err is captured on
  // the edge that leaves BUSY and holds until the next completion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done <= 1'b0;
      err  <= 1'b0;
    end else begin
      done <= (state == ST_DONE);
      if (busy && rdy_sel) begin
        err <= (rsp_sel != SLRSP_OKAY);
      end else if (busy && expired) begin
        err <= 1'b1;
      end
    end
  end

`ifdef BUS_MASTER_TIMEOUT_EN
  // Timeout status captured alongside err; a ready clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timeout <= 1'b0;
    end else if (busy && rdy_sel) begin
      timeout <= 1'b0;
    end else if (busy && expired) begin
      timeout <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: doc/bus_master_ctrl.md
BUS_MASTER_CTRL -- requirements
Module: bus_master_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, meaning HADDR/req_addr width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning HWDATA/req_wdata width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 16, meaning the wait-for-ready limit in BUSY cycles.
REQ-004 SHALL have ports, one per line:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req_valid  in  1  command request.
- req_ready  out  1  command accepted when high with req_valid.
- req_addr  in  ADDR_W  target address.
- req_wdata  in  DATA_W  write data.
- req_write  in  1  1 = write, 0 = read.
- HADDR  out  ADDR_W  bus address to slaves.
- HWDATA  out  DATA_W  bus write data to slaves.
- HWRITE  out  1  bus direction.
- hsel_1  out  1  slave 1 select.
- hsel_2  out  1  slave 2 select.
- sl_rdy_1  in  1  slave 1 ready.
- sl_rdy_2  in  1  slave 2 ready.
- slrsp_1  in  1  slave 1 response (1 = OKAY, 0 = error).
- slrsp_2  in  1  slave 2 response (1 = OKAY, 0 = error).
- done  out  1  one-cycle transfer-complete pulse.
- err  out  1  error status, valid while done is high.
- timeout  out  1  timeout status, valid while done is high.

Function
REQ-005 SHALL implement FSM states IDLE, BUSY and DONE.
REQ-006 SHALL drive req_ready = 1 only in IDLE; req_valid outside IDLE is ignored.
REQ-007 On an edge in IDLE with req_valid = 1, SHALL register req_addr, req_wdata and req_write into HADDR, HWDATA and HWRITE, then enter BUSY.
REQ-008 SHALL decode HADDR[ADDR_W-1] as 0 -> slave 1 and 1 -> slave 2.
REQ-009 SHALL assert exactly one hsel, per the decode, for every cycle in BUSY, and no hsel in IDLE or DONE.
REQ-010 In BUSY, SHALL sample only the selected slave's sl_rdy and ignore the unselected slave's sl_rdy and slrsp.
REQ-011 When the selected sl_rdy = 1, SHALL capture err = ~slrsp of that slave and timeout = 0, then enter DONE.
REQ-012 In DONE, SHALL hold done = 1 for exactly one cycle, then return to IDLE.
REQ-013 Latency: with accept at edge k and ready sampled at edge k+1, done SHALL be high during the cycle following edge k+2.
REQ-014 HADDR, HWDATA and HWRITE SHALL change only on accept and SHALL hold their values after the transfer.
REQ-015 err and timeout SHALL hold their last value until the next DONE.

Reset
REQ-016 While rst = 0, SHALL hold state IDLE, HADDR = 0, HWDATA = 0, HWRITE = 0, hsel_1/hsel_2 = 0, done = 0, err = 0 and timeout = 0; req_ready reads 1.
REQ-017 Reset asserted mid-transfer SHALL deassert hsel immediately, without waiting for clk, and SHALL abandon the transfer with no done pulse.

Configuration
REQ-018 With macro BUS_MASTER_TIMEOUT_EN defined, a counter SHALL clear on entry to BUSY and increment each BUSY cycle without ready; reaching TIMEOUT_CYCLES SHALL enter DONE with err = 1 and timeout = 1.
REQ-019 If ready and the limit coincide on the same edge, ready SHALL win.
REQ-020 Without BUS_MASTER_TIMEOUT_EN, BUSY SHALL wait indefinitely, timeout SHALL be tied to 0, and no counter logic SHALL be synthesized.

Structure
REQ-021 A shared package SHALL hold the FSM state encodings, default ADDR_W/DATA_W, the slave-select bit index and the slrsp OKAY value.
REQ-022 The timeout counter SHALL be the sub-module bus_wait_timer, instantiated only under BUS_MASTER_TIMEOUT_EN.

Verification
REQ-023 Write to slave 1: req_addr=16'h0008, req_wdata=20, sl_rdy_1 high one cycle after accept, slrsp_1=1 -> hsel_1 high 1 cycle, HADDR=16'h0008, HWDATA=20, done pulse, err=0.
REQ-024 Slave 2 read with delay: req_addr=16'h8004, req_write=0, sl_rdy_2 after 5 BUSY cycles, slrsp_2=0 -> hsel_2 high 5 cycles, hsel_1 never high, done with err=1.
REQ-025 Unselected ready: slave 1 target, sl_rdy_2=1 throughout, sl_rdy_1 after 3 cycles -> transfer completes only after sl_rdy_1.
REQ-026 Timeout (macro on, TIMEOUT_CYCLES=4): no ready -> done after 4 BUSY cycles with err=1 and timeout=1; a ready on the 4th edge -> timeout=0.
REQ-027 Reset mid-BUSY: rst low between clock edges -> hsel drops asynchronously, no done pulse, req_ready=1, next request completes normally.
